// File: rtl/csr_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : csr_regfile
// Description : LoongArch control/status register file. Combinational CSR
//               reads, masked CSR writes, exception entry / ERTN state
//               save-restore, constant-frequency timer and interrupt
//               pending logic.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_regfile #(
  parameter int TIMER_W = 32  // only 32 is supported
) (
  input  logic        clk,
  input  logic        resetn,
  // CSR access port
  input  logic [13:0] csr_num,
  input  logic        csr_re,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wvalue,
  input  logic [31:0] csr_wmask,
  // retirement events from writeback
  input  logic        ertn_flush,
  input  logic        wb_ex,
  input  logic [31:0] wb_pc,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_vaddr,
  // interrupt sources
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  // outputs to decode / fetch
  output logic        has_int,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry
);

  // CSR addresses
  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  // exception codes that capture a bad virtual address
  localparam logic [5:0]  ECODE_ADEF = 6'h08;
  localparam logic [5:0]  ECODE_ALE  = 6'h09;

  // LIE bit 10 has no interrupt source behind it
  localparam logic [12:0] LIE_MASK   = 13'h1BFF;

  // --------------------------------------------------------------------------
  // Register state
  // --------------------------------------------------------------------------
  logic [1:0]         crmd_plv;
  logic               crmd_ie;
  logic               crmd_da;
  logic [1:0]         prmd_pplv;
  logic               prmd_pie;
  logic [12:0]        ecfg_lie;
  logic [1:0]         estat_sw;
  logic [7:0]         estat_hw;
  logic               estat_ti;
  logic               estat_ipi;
  logic [5:0]         estat_ecode;
  logic [8:0]         estat_esubcode;
  logic [31:0]        era;
  logic [31:0]        badv;
  logic [25:0]        eentry_va;
  logic [31:0]        tid;
  logic               tcfg_en;
  logic               tcfg_periodic;
  logic [29:0]        tcfg_initval;
  logic [TIMER_W-1:0] tval;

  // --------------------------------------------------------------------------
  // Write decode. Software writes are dropped entirely while an exception
  // retires, so every software write strobe is qualified by sw_we.
  // --------------------------------------------------------------------------
  logic        sw_we;
  logic [31:0] wr_bits;   // bits being set by the masked write
  logic [31:0] keep;      // bits preserved from the old value
  logic        wr_crmd;
  logic        wr_prmd;
  logic        wr_ecfg;
  logic        wr_estat;
  logic        wr_era;
  logic        wr_badv;
  logic        wr_eentry;
  logic        wr_tid;
  logic        wr_tcfg;
  logic        wr_ticlr;

  assign sw_we     = csr_we & ~wb_ex;
  assign wr_bits   = csr_wvalue & csr_wmask;
  assign keep      = ~csr_wmask;

  assign wr_crmd   = sw_we & (csr_num == CSR_CRMD);
  assign wr_prmd   = sw_we & (csr_num == CSR_PRMD);
  assign wr_ecfg   = sw_we & (csr_num == CSR_ECFG);
  assign wr_estat  = sw_we & (csr_num == CSR_ESTAT);
  assign wr_era    = sw_we & (csr_num == CSR_ERA);
  assign wr_badv   = sw_we & (csr_num == CSR_BADV);
  assign wr_eentry = sw_we & (csr_num == CSR_EENTRY);
  assign wr_tid    = sw_we & (csr_num == CSR_TID);
  assign wr_tcfg   = sw_we & (csr_num == CSR_TCFG);
  assign wr_ticlr  = sw_we & (csr_num == CSR_TICLR);

  // merged write data for the registers with narrow fields
  logic [3:0]  crmd_wdata;
  logic [2:0]  prmd_wdata;
  logic [31:0] tcfg_wdata;

  assign crmd_wdata = wr_bits[3:0] | ({crmd_da, crmd_ie, crmd_plv} & keep[3:0]);
  assign prmd_wdata = wr_bits[2:0] | ({prmd_pie, prmd_pplv} & keep[2:0]);
  assign tcfg_wdata = wr_bits | ({tcfg_initval, tcfg_periodic, tcfg_en} & keep);

  // --------------------------------------------------------------------------
  // Timer events. A TCFG write in the same cycle overrides the countdown,
  // including a would-be expiry.
  // --------------------------------------------------------------------------
  logic timer_hit;
  logic ticlr_clr;

  assign timer_hit = tcfg_en & (tval == '0) & ~wr_tcfg;
  assign ticlr_clr = wr_ticlr & wr_bits[0];

  // CRMD: exception drops to kernel with interrupts off, ERTN restores.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd_plv <= 2'd0;
      crmd_ie  <= 1'b0;
      crmd_da  <= 1'b1;
    end else if (wb_ex) begin
      crmd_plv <= 2'd0;
      crmd_ie  <= 1'b0;
    end else if (ertn_flush) begin
      crmd_plv <= prmd_pplv;
      crmd_ie  <= prmd_pie;
    end else if (wr_crmd) begin
      crmd_plv <= crmd_wdata[1:0];
      crmd_ie  <= crmd_wdata[2];
      crmd_da  <= crmd_wdata[3];
    end
  end

  // PRMD: snapshot of PLV/IE taken at exception entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prmd_pplv <= 2'd0;
      prmd_pie  <= 1'b0;
    end else if (wb_ex) begin
      prmd_pplv <= crmd_plv;
      prmd_pie  <= crmd_ie;
    end else if (wr_prmd) begin
      prmd_pplv <= prmd_wdata[1:0];
      prmd_pie  <= prmd_wdata[2];
    end
  end

  // ECFG: local interrupt enables.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ecfg_lie <= 13'd0;
    end else if (wr_ecfg) begin
      ecfg_lie <= (wr_bits[12:0] | (ecfg_lie & keep[12:0])) & LIE_MASK;
    end
  end

  // ESTAT software interrupt bits IS[1:0].
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      estat_sw <= 2'd0;
    end else if (wr_estat) begin
      estat_sw <= wr_bits[1:0] | (estat_sw & keep[1:0]);
    end
  end

  // ESTAT hardware and IPI bits: level sample of the lines every cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      estat_hw  <= 8'd0;
      estat_ipi <= 1'b0;
    end else begin
      estat_hw  <= hw_int_in;
      estat_ipi <= ipi_int_in;
    end
  end

  // ESTAT timer flag: set on expiry, cleared via TICLR; expiry wins a tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      estat_ti <= 1'b0;
    end else if (timer_hit) begin
      estat_ti <= 1'b1;
    end else if (ticlr_clr) begin
      estat_ti <= 1'b0;
    end
  end

  // ESTAT exception cause, recorded only by hardware.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      estat_ecode    <= 6'd0;
      estat_esubcode <= 9'd0;
    end else if (wb_ex) begin
      estat_ecode    <= wb_ecode;
      estat_esubcode <= wb_esubcode;
    end
  end

  // ERA: return address captured at exception entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      era <= 32'd0;
    end else if (wb_ex) begin
      era <= wb_pc;
    end else if (wr_era) begin
      era <= wr_bits | (era & keep);
    end
  end

  // BADV: only address-type exceptions carry a faulting address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badv <= 32'd0;
    end else if (wb_ex) begin
      if ((wb_ecode == ECODE_ADEF) || (wb_ecode == ECODE_ALE)) begin
        badv <= wb_vaddr;
      end
    end else if (wr_badv) begin
      badv <= wr_bits | (badv & keep);
    end
  end

  // EENTRY: 64-byte aligned exception vector.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      eentry_va <= 26'd0;
    end else if (wr_eentry) begin
      eentry_va <= wr_bits[31:6] | (eentry_va & keep[31:6]);
    end
  end

  // SAVE0-3 scratch registers.
  logic [3:0] wr_save;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_save
      logic [31:0] value;

      assign wr_save[i] = sw_we & (csr_num == (CSR_SAVE0 + 14'(i)));

      // one scratch word
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          value <= 32'd0;
        end else if (wr_save[i]) begin
          value <= wr_bits | (value & keep);
        end
      end
    end
  endgenerate

  // TID: timer identifier, plain storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tid <= 32'd0;
    end else if (wr_tid) begin
      tid <= wr_bits | (tid & keep);
    end
  end

  // TCFG: enable, periodic and initial value of the timer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcfg_en       <= 1'b0;
      tcfg_periodic <= 1'b0;
      tcfg_initval  <= 30'd0;
    end else if (wr_tcfg) begin
      tcfg_en       <= tcfg_wdata[0];
      tcfg_periodic <= tcfg_wdata[1];
      tcfg_initval  <= tcfg_wdata[31:2];
    end
  end

  // TVAL: load on TCFG write, count down while enabled, park at all-ones
  // once a one-shot timer has expired.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tval <= '1;
    end else if (wr_tcfg) begin
      tval <= TIMER_W'({tcfg_wdata[31:2], 2'b00});
    end else if (tcfg_en) begin
      if (tval == '0) begin
        tval <= tcfg_periodic ? TIMER_W'({tcfg_initval, 2'b00}) : '1;
      end else if (tval != '1) begin
        tval <= tval - TIMER_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  logic [12:0] estat_is;
  logic [31:0] rd_data;

  assign estat_is = {estat_ipi, estat_ti, 1'b0, estat_hw, estat_sw};

  // Read mux: unmapped addresses and TICLR read as zero.
  always_comb begin
    rd_data = 32'd0;
    case (csr_num)
      CSR_CRMD:   rd_data = {28'd0, crmd_da, crmd_ie, crmd_plv};
      CSR_PRMD:   rd_data = {29'd0, prmd_pie, prmd_pplv};
      CSR_ECFG:   rd_data = {19'd0, ecfg_lie};
      CSR_ESTAT:  rd_data = {1'b0, estat_esubcode, estat_ecode, 3'd0, estat_is};
      CSR_ERA:    rd_data = era;
      CSR_BADV:   rd_data = badv;
      CSR_EENTRY: rd_data = {eentry_va, 6'd0};
      CSR_SAVE0:  rd_data = g_save[0].value;
      CSR_SAVE1:  rd_data = g_save[1].value;
      CSR_SAVE2:  rd_data = g_save[2].value;
      CSR_SAVE3:  rd_data = g_save[3].value;
      CSR_TID:    rd_data = tid;
      CSR_TCFG:   rd_data = {tcfg_initval, tcfg_periodic, tcfg_en};
      CSR_TVAL:   rd_data = 32'(tval);
      default:    rd_data = 32'd0;
    endcase
  end

  assign csr_rvalue = csr_re ? rd_data : 32'd0;
  assign has_int    = crmd_ie & (|(estat_is & ecfg_lie));
  assign ex_entry   = {eentry_va, 6'd0};
  assign ertn_entry = era;

endmodule
`default_nettype wire
